// File: rtl/snn_axis_pkg.sv
// Shared definitions for the spike-count AXI-Stream reporter: beat field layout and TX state.
// Pure declarations; no latency or flow control lives here.
package snn_axis_pkg;

    localparam int IDX_MSB = 31;
    localparam int IDX_LSB = 24;
    localparam int FRM_MSB = 23;
    localparam int FRM_LSB = 16;
    localparam int CNT_MSB = 15;
    localparam int CNT_LSB = 0;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/spike_counter.sv
// Saturating per-neuron spike counter; o_count_next is the count including this cycle's spike.
// One-cycle update while i_en is high; i_clr restarts from zero on the following cycle.
module spike_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_spike,
    output logic [CNT_W-1:0] o_count_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_comb begin
        o_count_next = r_count;
        if (i_spike && (r_count != CNT_MAX)) begin
            o_count_next = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= i_clr ? '0 : o_count_next;
        end
    end

endmodule

// File: rtl/spike_axis_tx.sv
// Counts output spikes over WINDOW enabled cycles and streams one 32-bit beat per neuron; first beat valid 1 cycle after window end.
// Holds beats stable under tready backpressure; a window ending mid-frame is dropped and flagged sticky.
module spike_axis_tx
    import snn_axis_pkg::*;
#(
    parameter int N_OUT  = 4,
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_OUT-1:0] spikes_in,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             drop_flag
);

    localparam int               WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [7:0]       IDX_LAST = 8'(N_OUT - 1);

    logic [WIN_W-1:0] r_win;
    logic             w_win_end;

    logic [CNT_W-1:0] w_cnt_next [N_OUT];
    logic [CNT_W-1:0] r_snap     [N_OUT];
    logic [7:0]       r_frame;
    logic [7:0]       r_snap_frm;
    logic             r_drop;

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [7:0]       r_idx;
    logic [7:0]       w_idx_nxt;
    logic             w_load;
    logic             w_drop;
    logic             w_last_xfer;
    logic [CNT_W-1:0] w_cnt_sel;

    assign w_win_end = en && (r_win == WIN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
        end else if (en) begin
            r_win <= w_win_end ? '0 : r_win + WIN_W'(1);
        end
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_cnt
        spike_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_en        (en),
            .i_clr       (w_win_end),
            .i_spike     (spikes_in[gi]),
            .o_count_next(w_cnt_next[gi])
        );
    end

    // A final-beat transfer coinciding with a window end hands straight over to the new frame.
    assign w_last_xfer = (r_state == TX_SEND) && m_axis_tready && (r_idx == IDX_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (w_win_end) begin
                    w_state_nxt = TX_SEND;
                    w_idx_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            TX_SEND: begin
                if (m_axis_tready) begin
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt = '0;
                        if (w_win_end) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = TX_IDLE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 8'd1;
                    end
                end
                if (w_win_end && !w_last_xfer) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Frame number advances on every window end so dropped frames leave a visible gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_snap[i] <= '0;
            end
            r_frame    <= '0;
            r_snap_frm <= '0;
            r_drop     <= 1'b0;
        end else begin
            if (w_win_end) begin
                r_frame <= r_frame + 8'd1;
            end
            if (w_load) begin
                for (int i = 0; i < N_OUT; i++) begin
                    r_snap[i] <= w_cnt_next[i];
                end
                r_snap_frm <= r_frame;
            end
            if (w_drop) begin
                r_drop <= 1'b1;
            end
        end
    end

    always_comb begin
        w_cnt_sel = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (r_idx == 8'(i)) begin
                w_cnt_sel = r_snap[i];
            end
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        if (r_state == TX_SEND) begin
            m_axis_tdata[IDX_MSB:IDX_LSB] = r_idx;
            m_axis_tdata[FRM_MSB:FRM_LSB] = r_snap_frm;
            m_axis_tdata[CNT_MSB:CNT_LSB] = 16'(w_cnt_sel);
        end
    end

    assign m_axis_tvalid = (r_state == TX_SEND);
    assign m_axis_tlast  = (r_state == TX_SEND) && (r_idx == IDX_LAST);
    assign drop_flag     = r_drop;

endmodule
